dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: single outstanding request, fixed wait-state access,
// RISC-V style byte/half/word(/double) loads and stores with alignment checking.
module dmem_lsu #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // Handshake: a request transfers on a rising edge with req_valid=1 while req_ready=1;
  // a response transfers on a rising edge with rsp_valid=1 and rsp_ready=1, and the
  // response outputs hold stable until that edge.

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = ADDR_W - LANE_W;
  localparam int WORDS  = 2 ** IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          funct3_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem [WORDS];

  logic                req_legal;
  logic [2:0]          req_mask;

  always_comb begin
    req_legal = 1'b0;
    if (req_we) begin
      req_legal = (req_funct3[2] == 1'b0) && ((req_funct3[1:0] != 2'd3) || (DATA_W == 64));
    end else begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: req_legal = 1'b1;
        3'd3, 3'd6:                   req_legal = (DATA_W == 64);
        default:                      req_legal = 1'b0;
      endcase
    end
    // Access size is 2**funct3[1:0] bytes; any set low address bit below it is misaligned.
    req_mask = 3'((4'd1 << req_funct3[1:0]) - 4'd1);
    if ((3'(req_addr[LANE_W-1:0]) & req_mask) != 3'd0) req_legal = 1'b0;
  end

  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  logic [3:0]        nbytes;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] ld_val;
  logic              last_wait;

  assign idx       = addr_q[ADDR_W-1:LANE_W];
  assign lane      = addr_q[LANE_W-1:0];
  assign nbytes    = 4'd1 << funct3_q[1:0];
  assign be        = NB'((16'd1 << nbytes) - 16'd1) << lane;
  assign wsh       = wdata_q << {lane, 3'b000};
  assign rsh       = mem[idx] >> {lane, 3'b000};
  assign last_wait = (state_q == S_WAIT) && (cnt_q == 3'(WAIT_STATES));

  always_comb begin
    case (funct3_q)
      3'd0:    ld_val = DATA_W'($signed(rsh[7:0]));
      3'd1:    ld_val = DATA_W'($signed(rsh[15:0]));
      3'd2:    ld_val = DATA_W'($signed(rsh[31:0]));
      3'd4:    ld_val = DATA_W'(rsh[7:0]);
      3'd5:    ld_val = DATA_W'(rsh[15:0]);
      3'd6:    ld_val = DATA_W'(rsh[31:0]);
      default: ld_val = rsh;
    endcase
  end

  // Storage is never reset; a reset during WAIT drops state_q so last_wait never fires.
  always_ff @(posedge clk) begin
    if (last_wait && we_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            cnt_q    <= 3'd0;
            if (req_legal) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_RESP;
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (last_wait) begin
            state_q <= S_RESP;
            rdata_q <= we_q ? '0 : ld_val;
            err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
